// File: rtl/spi_cfg_sequencer.sv
// SPI configuration sequencer: streams a word table to an SPI engine,
// interleaves single host transfers, and finishes a table with a SYNC pulse.
module spi_cfg_sequencer #(
    parameter int NUM_WORDS   = 16,
    parameter int SYNC_CYCLES = 4,
    parameter int TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start_i,
    output logic [7:0]  cfg_addr_o,
    input  logic [33:0] cfg_data_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_err_o,
    input  logic        host_req_i,
    input  logic [1:0]  host_sel_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_busy_o,
    output logic        host_done_o,
    output logic [31:0] host_rdata_o,
    output logic        spi_go_o,
    input  logic        spi_done_i,
    output logic [31:0] spi_in_o,
    input  logic [31:0] spi_out_i,
    output logic [1:0]  spi_sel_o,
    output logic        sync_o
);

    typedef enum logic [2:0] {
        IDLE, LOAD, GO_WAIT, REL_WAIT, NEXT, SYNC_P
    } state_e;

    localparam logic [7:0]  LAST_ADDR = 8'(NUM_WORDS - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  SYNC_LAST = 8'(SYNC_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  cfg_addr_q, cfg_addr_d;
    logic        cfg_busy_q, cfg_busy_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        host_busy_q, host_busy_d;
    logic        host_done_q, host_done_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic [1:0]  host_sel_q, host_sel_d;
    logic [31:0] host_wdata_q, host_wdata_d;
    logic        spi_go_q, spi_go_d;
    logic [31:0] spi_in_q, spi_in_d;
    logic [1:0]  spi_sel_q, spi_sel_d;
    logic        sync_q, sync_d;
    logic        src_host_q, src_host_d;
    logic [31:0] resp_q, resp_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  sync_cnt_q, sync_cnt_d;
    logic        tmo_hit;
    logic        abort;

    assign tmo_hit = (tmo_q == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cfg_start_i || host_busy_q || host_req_i)
                    state_d = LOAD;
            end
            LOAD: begin
                if (!src_host_q && cfg_data_i[33:32] == 2'b11)
                    state_d = SYNC_P;
                else
                    state_d = GO_WAIT;
            end
            GO_WAIT: begin
                if (spi_done_i)   state_d = REL_WAIT;
                else if (tmo_hit) state_d = IDLE;
            end
            REL_WAIT: begin
                if (!spi_done_i)  state_d = NEXT;
                else if (tmo_hit) state_d = IDLE;
            end
            NEXT: begin
                if (src_host_q)                    state_d = IDLE;
                else if (cfg_addr_q == LAST_ADDR)  state_d = SYNC_P;
                else                               state_d = LOAD;
            end
            SYNC_P: begin
                if (sync_cnt_q == SYNC_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the only exit from a wait state
    // straight to IDLE is a timeout, which aborts the active source.
    always_comb begin
        cfg_addr_d   = cfg_addr_q;
        cfg_busy_d   = cfg_busy_q;
        cfg_done_d   = 1'b0;
        cfg_err_d    = cfg_err_q;
        host_busy_d  = host_busy_q;
        host_done_d  = 1'b0;
        host_rdata_d = host_rdata_q;
        host_sel_d   = host_sel_q;
        host_wdata_d = host_wdata_q;
        spi_go_d     = spi_go_q;
        spi_in_d     = spi_in_q;
        spi_sel_d    = spi_sel_q;
        sync_d       = sync_q;
        src_host_d   = src_host_q;
        resp_d       = resp_q;
        sync_cnt_d   = sync_cnt_q;
        abort        = 1'b0;

        if (state_d != state_q)
            tmo_d = '0;
        else if (state_q == GO_WAIT || state_q == REL_WAIT)
            tmo_d = tmo_q + 16'd1;
        else
            tmo_d = tmo_q;

        if (host_req_i && !host_busy_q) begin
            host_busy_d  = 1'b1;
            host_sel_d   = host_sel_i;
            host_wdata_d = host_wdata_i;
        end

        unique case (state_q)
            IDLE: begin
                if (cfg_start_i) begin
                    cfg_addr_d = '0;
                    cfg_busy_d = 1'b1;
                    cfg_err_d  = 1'b0;
                    src_host_d = 1'b0;
                end else if (host_busy_q || host_req_i) begin
                    src_host_d = 1'b1;
                end
            end
            LOAD: begin
                if (state_d == GO_WAIT) begin
                    spi_go_d  = 1'b1;
                    spi_sel_d = src_host_q ? host_sel_q : cfg_data_i[33:32];
                    spi_in_d  = src_host_q ? host_wdata_q : cfg_data_i[31:0];
                end else begin
                    sync_d     = 1'b1;
                    sync_cnt_d = '0;
                end
            end
            GO_WAIT: begin
                if (spi_done_i) begin
                    spi_go_d = 1'b0;
                    resp_d   = spi_out_i;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            REL_WAIT: begin
                if (spi_done_i && tmo_hit) abort = 1'b1;
            end
            NEXT: begin
                if (src_host_q) begin
                    host_rdata_d = resp_q;
                    host_done_d  = 1'b1;
                    host_busy_d  = 1'b0;
                end else if (cfg_addr_q == LAST_ADDR) begin
                    sync_d     = 1'b1;
                    sync_cnt_d = '0;
                end else begin
                    cfg_addr_d = cfg_addr_q + 8'd1;
                end
            end
            SYNC_P: begin
                if (sync_cnt_q == SYNC_LAST) begin
                    sync_d     = 1'b0;
                    cfg_done_d = 1'b1;
                    cfg_busy_d = 1'b0;
                end else begin
                    sync_cnt_d = sync_cnt_q + 8'd1;
                end
            end
            default: ;
        endcase

        if (abort) begin
            spi_go_d  = 1'b0;
            cfg_err_d = 1'b1;
            if (src_host_q) begin
                host_done_d  = 1'b1;
                host_busy_d  = 1'b0;
                host_rdata_d = '0;
            end else begin
                cfg_done_d = 1'b1;
                cfg_busy_d = 1'b0;
            end
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_addr_q   <= '0;
            cfg_busy_q   <= 1'b0;
            cfg_done_q   <= 1'b0;
            cfg_err_q    <= 1'b0;
            host_busy_q  <= 1'b0;
            host_done_q  <= 1'b0;
            host_rdata_q <= '0;
            host_sel_q   <= '0;
            host_wdata_q <= '0;
            spi_go_q     <= 1'b0;
            spi_in_q     <= '0;
            spi_sel_q    <= '0;
            sync_q       <= 1'b0;
            src_host_q   <= 1'b0;
            resp_q       <= '0;
            tmo_q        <= '0;
            sync_cnt_q   <= '0;
        end else begin
            cfg_addr_q   <= cfg_addr_d;
            cfg_busy_q   <= cfg_busy_d;
            cfg_done_q   <= cfg_done_d;
            cfg_err_q    <= cfg_err_d;
            host_busy_q  <= host_busy_d;
            host_done_q  <= host_done_d;
            host_rdata_q <= host_rdata_d;
            host_sel_q   <= host_sel_d;
            host_wdata_q <= host_wdata_d;
            spi_go_q     <= spi_go_d;
            spi_in_q     <= spi_in_d;
            spi_sel_q    <= spi_sel_d;
            sync_q       <= sync_d;
            src_host_q   <= src_host_d;
            resp_q       <= resp_d;
            tmo_q        <= tmo_d;
            sync_cnt_q   <= sync_cnt_d;
        end
    end

    assign cfg_addr_o   = cfg_addr_q;
    assign cfg_busy_o   = cfg_busy_q;
    assign cfg_done_o   = cfg_done_q;
    assign cfg_err_o    = cfg_err_q;
    assign host_busy_o  = host_busy_q;
    assign host_done_o  = host_done_q;
    assign host_rdata_o = host_rdata_q;
    assign spi_go_o     = spi_go_q;
    assign spi_in_o     = spi_in_q;
    assign spi_sel_o    = spi_sel_q;
    assign sync_o       = sync_q;

endmodule
